// File: rtl/fft_seq_pkg.sv
// Shared types and constants for the FFT frame sequencer: FSM states,
// GPIO control-word layout and the FFT configuration word format.
package fft_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONFIG = 2'd1,
    ST_STREAM = 2'd2,
    ST_SKIP   = 2'd3
  } seq_state_e;

  localparam int GPIO_ENABLE_BIT = 0;
  localparam int GPIO_AVG_LSB    = 1;
  localparam int GPIO_THR_LSB    = 6;
  localparam int GPIO_FIELD_W    = 5;
  localparam int GPIO_USED_W     = 11;

  typedef struct packed {
    logic                    enable;
    logic [GPIO_FIELD_W-1:0] log_avg;
    logic [GPIO_FIELD_W-1:0] log_thr;
  } gpio_fields_t;

  // Scaling schedule in [15:1], bit 0 selects the forward transform.
  function automatic logic [15:0] cfg_word(input logic [14:0] scale_sch);
    return {scale_sch, 1'b1};
  endfunction

endpackage

// File: rtl/gpio_cfg_decoder.sv
// Registers the GPIO control word once and splits it into enable,
// averaging count and a clamped throttle exponent.
module gpio_cfg_decoder
  import fft_seq_pkg::*;
#(
  parameter int MAX_LOG_THROTTLE = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  gpio,
  output gpio_fields_t fields
);

  logic [GPIO_USED_W-1:0]  gpio_d, gpio_q;
  logic [GPIO_FIELD_W-1:0] thr_raw;
  logic                    unused_gpio_hi;

  assign unused_gpio_hi = ^gpio[31:GPIO_USED_W];
  assign gpio_d         = gpio[GPIO_USED_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gpio_q <= '0;
    else        gpio_q <= gpio_d;
  end

  always_comb begin
    thr_raw        = gpio_q[GPIO_THR_LSB +: GPIO_FIELD_W];
    fields.enable  = gpio_q[GPIO_ENABLE_BIT];
    fields.log_avg = gpio_q[GPIO_AVG_LSB +: GPIO_FIELD_W];
    fields.log_thr = (thr_raw > GPIO_FIELD_W'(MAX_LOG_THROTTLE))
                   ? GPIO_FIELD_W'(MAX_LOG_THROTTLE) : thr_raw;
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frames the filter stream for the FFT core: programs the core, inserts tlast
// every 2^LOG_N samples and throttles by discarding whole frames.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int          AXIS_TDATA_WIDTH = 16,
  parameter int          LOG_N            = 8,
  parameter int          CFG_TDATA_WIDTH  = 16,
  parameter logic [14:0] SCALE_SCH        = 15'h2AB,
  parameter int          MAX_LOG_THROTTLE = 10
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [31:0]                 GPIO,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_filter_tdata,
  input  logic                        S_AXIS_filter_tvalid,
  output logic                        S_AXIS_filter_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_fft_tdata,
  output logic                        M_AXIS_fft_tvalid,
  input  logic                        M_AXIS_fft_tready,
  output logic                        M_AXIS_fft_tlast,
  output logic [CFG_TDATA_WIDTH-1:0]  M_AXIS_cfg_tdata,
  output logic                        M_AXIS_cfg_tvalid,
  input  logic                        M_AXIS_cfg_tready,
  output logic [GPIO_FIELD_W-1:0]     avg_log_count,
  output logic                        frame_start
);

  localparam int                         SKIP_W      = LOG_N + MAX_LOG_THROTTLE;
  localparam logic [LOG_N-1:0]           LAST_SAMPLE = '1;
  localparam logic [CFG_TDATA_WIDTH-1:0] CFG_WORD    = CFG_TDATA_WIDTH'(cfg_word(SCALE_SCH));

  gpio_fields_t fields;

  seq_state_e              state_d, state_q;
  logic [LOG_N-1:0]        sample_cnt_d, sample_cnt_q;
  logic [SKIP_W-1:0]       skip_cnt_d, skip_cnt_q;
  logic [GPIO_FIELD_W-1:0] log_avg_d, log_avg_q;
  logic [GPIO_FIELD_W-1:0] log_thr_d, log_thr_q;
  logic                    rst_done_d, rst_done_q;
  logic [SKIP_W-1:0]       skip_frames, skip_last;
  logic                    last_beat, frame_done, allow_skip;

  gpio_cfg_decoder #(
    .MAX_LOG_THROTTLE(MAX_LOG_THROTTLE)
  ) u_decoder (
    .clk    (aclk),
    .rst_n  (aresetn),
    .gpio   (GPIO),
    .fields (fields)
  );

  assign avg_log_count = log_avg_q;
  assign rst_done_d    = 1'b1;

  // Skipped span is (2^thr - 1) whole frames, counted in samples.
  always_comb begin
    skip_frames = (SKIP_W'(1) << log_thr_q) - SKIP_W'(1);
    skip_last   = (skip_frames << LOG_N) - SKIP_W'(1);
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d              = state_q;
    sample_cnt_d         = sample_cnt_q;
    skip_cnt_d           = skip_cnt_q;
    log_avg_d            = log_avg_q;
    log_thr_d            = log_thr_q;
    last_beat            = 1'b0;
    frame_done           = 1'b0;
    allow_skip           = 1'b0;
    S_AXIS_filter_tready = 1'b0;
    M_AXIS_fft_tdata     = '0;
    M_AXIS_fft_tvalid    = 1'b0;
    M_AXIS_fft_tlast     = 1'b0;
    M_AXIS_cfg_tdata     = '0;
    M_AXIS_cfg_tvalid    = 1'b0;
    frame_start          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        S_AXIS_filter_tready = rst_done_q;
        sample_cnt_d         = '0;
        skip_cnt_d           = '0;
        if (fields.enable) begin
          log_avg_d = fields.log_avg;
          log_thr_d = fields.log_thr;
          state_d   = ST_CONFIG;
        end
      end
      ST_CONFIG: begin
        M_AXIS_cfg_tvalid = 1'b1;
        M_AXIS_cfg_tdata  = CFG_WORD;
        if (M_AXIS_cfg_tready) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        last_beat            = (sample_cnt_q == LAST_SAMPLE);
        M_AXIS_fft_tvalid    = S_AXIS_filter_tvalid;
        M_AXIS_fft_tdata     = S_AXIS_filter_tdata;
        M_AXIS_fft_tlast     = last_beat;
        S_AXIS_filter_tready = M_AXIS_fft_tready;
        if (S_AXIS_filter_tvalid && M_AXIS_fft_tready) begin
          sample_cnt_d = sample_cnt_q + LOG_N'(1);
          frame_start  = (sample_cnt_q == '0);
          frame_done   = last_beat;
          allow_skip   = last_beat;
        end
      end
      ST_SKIP: begin
        S_AXIS_filter_tready = 1'b1;
        if (!fields.enable) begin
          state_d    = ST_IDLE;
          skip_cnt_d = '0;
        end else if (S_AXIS_filter_tvalid) begin
          if (skip_cnt_q == skip_last) begin
            skip_cnt_d = '0;
            frame_done = 1'b1;
          end else begin
            skip_cnt_d = skip_cnt_q + SKIP_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The config word depends only on parameters, so a relatch never needs a new cfg beat.
    if (frame_done) begin
      if (!fields.enable) begin
        state_d = ST_IDLE;
      end else begin
        log_avg_d = fields.log_avg;
        log_thr_d = fields.log_thr;
        state_d   = (allow_skip && (fields.log_thr != '0)) ? ST_SKIP : ST_STREAM;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      sample_cnt_q <= '0;
      skip_cnt_q   <= '0;
      log_avg_q    <= '0;
      log_thr_q    <= '0;
      rst_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      skip_cnt_q   <= skip_cnt_d;
      log_avg_q    <= log_avg_d;
      log_thr_q    <= log_thr_d;
      rst_done_q   <= rst_done_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with 16-sample frames: config beat,
// framing, throttling, backpressure, enable drop, GPIO relatch and mid-frame reset.
module tb_fft_frame_sequencer;

  localparam int LOG_N = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] gpio = '0;
  logic [15:0] s_tdata = 16'h1000;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [15:0] fft_tdata;
  logic        fft_tvalid;
  logic        fft_tready = 1'b1;
  logic        fft_tlast;
  logic [15:0] cfg_tdata;
  logic        cfg_tvalid;
  logic        cfg_tready = 1'b1;
  logic [4:0]  avg_log_count;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_count = 0;
  int cfg_beats = 0;
  logic [15:0] q_data[$];
  bit          q_last[$];
  bit          q_fs[$];

  always #5 aclk = ~aclk;

  fft_frame_sequencer #(
    .AXIS_TDATA_WIDTH (16),
    .LOG_N            (LOG_N),
    .CFG_TDATA_WIDTH  (16),
    .SCALE_SCH        (15'h2AAB),
    .MAX_LOG_THROTTLE (10)
  ) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .GPIO                 (gpio),
    .S_AXIS_filter_tdata  (s_tdata),
    .S_AXIS_filter_tvalid (s_tvalid),
    .S_AXIS_filter_tready (s_tready),
    .M_AXIS_fft_tdata     (fft_tdata),
    .M_AXIS_fft_tvalid    (fft_tvalid),
    .M_AXIS_fft_tready    (fft_tready),
    .M_AXIS_fft_tlast     (fft_tlast),
    .M_AXIS_cfg_tdata     (cfg_tdata),
    .M_AXIS_cfg_tvalid    (cfg_tvalid),
    .M_AXIS_cfg_tready    (cfg_tready),
    .avg_log_count        (avg_log_count),
    .frame_start          (frame_start)
  );

  // Handshakes are recorded half a cycle before the edge that completes them.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (s_tvalid && s_tready) acc_count++;
      if (fft_tvalid && fft_tready) begin
        q_data.push_back(fft_tdata);
        q_last.push_back(fft_tlast);
        q_fs.push_back(frame_start);
      end
      if (cfg_tvalid && cfg_tready) cfg_beats++;
    end
  end

  // Source emits a fresh value after every accepted sample.
  always @(posedge aclk) begin
    #1;
    s_tdata = 16'h1000 + 16'(acc_count);
  end

  task automatic do_reset();
    aresetn    = 1'b0;
    gpio       = '0;
    s_tvalid   = 1'b1;
    fft_tready = 1'b1;
    cfg_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic wait_outputs(input int n, input int budget, input string name);
    int cyc;
    cyc = 0;
    while (q_data.size() < n && cyc < budget) begin
      @(negedge aclk); #1;
      cyc++;
    end
    n_checks++;
    if (q_data.size() < n) begin
      n_fail++;
      $display("FAIL %s timeout: outputs %0d, required %0d", name, q_data.size(), n);
    end
  endtask

  task automatic test_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b1;
    @(negedge aclk); #1;
    n_checks++;
    if ({s_tready, fft_tvalid, fft_tlast, cfg_tvalid, frame_start} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 00000",
               {s_tready, fft_tvalid, fft_tlast, cfg_tvalid, frame_start});
    end
    n_checks++;
    if (fft_tdata !== 16'h0 || cfg_tdata !== 16'h0 || avg_log_count !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_data: fft %h cfg %h avg %0d, required 0 0 0",
               fft_tdata, cfg_tdata, avg_log_count);
    end
    do_reset();
    @(negedge aclk); #1;
    n_checks++;
    if (s_tready !== 1'b1 || fft_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_drop: tready %b tvalid %b, required 1 0", s_tready, fft_tvalid);
    end
  endtask

  task automatic test_stream_basic();
    int base, cfg0, k, i;
    do_reset();
    base = q_data.size();
    cfg0 = cfg_beats;
    cfg_tready = 1'b0;
    gpio = 32'h1;
    for (int c = 0; c < 10 && !cfg_tvalid; c++) begin
      @(negedge aclk); #1;
    end
    n_checks++;
    if (cfg_tvalid !== 1'b1 || cfg_tdata !== 16'h5557) begin
      n_fail++;
      $display("FAIL cfg_beat: valid %b data %h, required 1 5557", cfg_tvalid, cfg_tdata);
    end
    repeat (3) begin
      @(negedge aclk); #1;
      n_checks++;
      if (cfg_tvalid !== 1'b1 || s_tready !== 1'b0 || fft_tvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_hold: valid %b tready %b fft_tvalid %b, required 1 0 0",
                 cfg_tvalid, s_tready, fft_tvalid);
      end
    end
    @(posedge aclk); #1 cfg_tready = 1'b1;
    wait_outputs(base + 48, 200, "stream_basic");
    n_checks++;
    if (cfg_beats - cfg0 !== 1) begin
      n_fail++;
      $display("FAIL cfg_count: got %0d, required 1", cfg_beats - cfg0);
    end
    for (k = 0; k < 48 && base + k < q_data.size(); k++) begin
      i = base + k;
      n_checks++;
      if (q_last[i] !== (k % 16 == 15) || q_fs[i] !== (k % 16 == 0)) begin
        n_fail++;
        $display("FAIL basic_frame[%0d]: last %b fs %b", k, q_last[i], q_fs[i]);
      end
      if (k > 0) begin
        n_checks++;
        if (q_data[i] !== q_data[i-1] + 16'd1) begin
          n_fail++;
          $display("FAIL basic_data[%0d]: got %h, required %h", k, q_data[i], q_data[i-1] + 16'd1);
        end
      end
    end
  endtask

  task automatic test_throttle();
    int base, k, i;
    logic [15:0] exp;
    do_reset();
    base = q_data.size();
    gpio = 32'h41;
    wait_outputs(base + 16, 100, "throttle_first");
    @(negedge aclk); #1;
    n_checks++;
    if (s_tready !== 1'b1 || fft_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_state: tready %b tvalid %b, required 1 0", s_tready, fft_tvalid);
    end
    wait_outputs(base + 48, 300, "throttle");
    for (k = 1; k < 48 && base + k < q_data.size(); k++) begin
      i = base + k;
      exp = q_data[i-1] + ((k % 16 == 0) ? 16'd17 : 16'd1);
      n_checks++;
      if (q_data[i] !== exp || q_last[i] !== (k % 16 == 15) || q_fs[i] !== (k % 16 == 0)) begin
        n_fail++;
        $display("FAIL throttle[%0d]: data %h last %b fs %b, required data %h",
                 k, q_data[i], q_last[i], q_fs[i], exp);
      end
    end
  endtask

  task automatic test_backpressure();
    int base, k, i, c;
    do_reset();
    base = q_data.size();
    gpio = 32'h1;
    for (c = 0; c < 400 && q_data.size() < base + 32; c++) begin
      @(posedge aclk); #1 fft_tready = ~fft_tready;
      @(negedge aclk); #1;
      if (fft_tvalid) begin
        n_checks++;
        if (s_tready !== fft_tready) begin
          n_fail++;
          $display("FAIL bp_mirror: tready %b, required %b", s_tready, fft_tready);
        end
      end
    end
    wait_outputs(base + 32, 1, "backpressure");
    fft_tready = 1'b1;
    for (k = 1; k < 32 && base + k < q_data.size(); k++) begin
      i = base + k;
      n_checks++;
      if (q_data[i] !== q_data[i-1] + 16'd1 || q_last[i] !== (k % 16 == 15)) begin
        n_fail++;
        $display("FAIL bp_data[%0d]: data %h last %b, required data %h",
                 k, q_data[i], q_last[i], q_data[i-1] + 16'd1);
      end
    end
  endtask

  task automatic test_enable_drop();
    int base, k;
    do_reset();
    base = q_data.size();
    gpio = 32'h1;
    wait_outputs(base + 6, 50, "enable_drop_start");
    gpio = 32'h0;
    repeat (40) @(posedge aclk);
    @(negedge aclk); #1;
    n_checks++;
    if (q_data.size() !== base + 16) begin
      n_fail++;
      $display("FAIL drop_count: outputs %0d, required 16", q_data.size() - base);
    end else begin
      n_checks++;
      if (q_last[base+15] !== 1'b1) begin
        n_fail++;
        $display("FAIL drop_tlast: got %b, required 1", q_last[base+15]);
      end
      for (k = 1; k < 16; k++) begin
        n_checks++;
        if (q_data[base+k] !== q_data[base+k-1] + 16'd1) begin
          n_fail++;
          $display("FAIL drop_data[%0d]: got %h, required %h",
                   k, q_data[base+k], q_data[base+k-1] + 16'd1);
        end
      end
    end
    n_checks++;
    if (fft_tvalid !== 1'b0 || s_tready !== 1'b1 || cfg_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_idle: tvalid %b tready %b cfg %b, required 0 1 0",
               fft_tvalid, s_tready, cfg_tvalid);
    end
  endtask

  task automatic test_gpio_change();
    int base, cfg0;
    do_reset();
    base = q_data.size();
    cfg0 = cfg_beats;
    gpio = 32'h1;
    wait_outputs(base + 5, 50, "gpio_change_start");
    gpio = 32'h5;
    for (int c = 0; c < 40 && q_data.size() < base + 16; c++) begin
      @(negedge aclk); #1;
      n_checks++;
      if (avg_log_count !== 5'd0) begin
        n_fail++;
        $display("FAIL avg_midframe: got %0d, required 0", avg_log_count);
      end
    end
    @(negedge aclk); #1;
    n_checks++;
    if (avg_log_count !== 5'd2 || frame_start !== 1'b1 || fft_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL avg_relatch: avg %0d fs %b tvalid %b, required 2 1 1",
               avg_log_count, frame_start, fft_tvalid);
    end
    wait_outputs(base + 32, 60, "gpio_change");
    n_checks++;
    if (cfg_beats - cfg0 !== 1) begin
      n_fail++;
      $display("FAIL relatch_cfg: beats %0d, required 1", cfg_beats - cfg0);
    end
    if (q_data.size() >= base + 32) begin
      n_checks++;
      if (q_data[base+16] !== q_data[base+15] + 16'd1 || q_fs[base+16] !== 1'b1 ||
          q_last[base+31] !== 1'b1) begin
        n_fail++;
        $display("FAIL relatch_frame: data %h fs %b last %b, required %h 1 1",
                 q_data[base+16], q_fs[base+16], q_last[base+31], q_data[base+15] + 16'd1);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int base, cfg0;
    bit any_last;
    do_reset();
    base = q_data.size();
    gpio = 32'h1;
    wait_outputs(base + 10, 50, "midreset_start");
    aresetn = 1'b0;
    #1;
    n_checks++;
    if ({s_tready, fft_tvalid, fft_tlast, cfg_tvalid, frame_start} !== 5'b0 ||
        fft_tdata !== 16'h0 || avg_log_count !== 5'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: ctrl %b data %h avg %0d, required 0",
               {s_tready, fft_tvalid, fft_tlast, cfg_tvalid, frame_start}, fft_tdata, avg_log_count);
    end
    any_last = 1'b0;
    for (int k = 0; k < 10 && base + k < q_data.size(); k++) any_last |= q_last[base+k];
    n_checks++;
    if (any_last !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_tlast: got %b, required 0", any_last);
    end
    @(posedge aclk); #1 aresetn = 1'b1;
    base = q_data.size();
    cfg0 = cfg_beats;
    wait_outputs(base + 16, 100, "midreset_restart");
    n_checks++;
    if (cfg_beats - cfg0 !== 1) begin
      n_fail++;
      $display("FAIL restart_cfg: beats %0d, required 1", cfg_beats - cfg0);
    end
    if (q_data.size() >= base + 16) begin
      n_checks++;
      if (q_fs[base] !== 1'b1 || q_last[base+14] !== 1'b0 || q_last[base+15] !== 1'b1) begin
        n_fail++;
        $display("FAIL restart_frame: fs %b last14 %b last15 %b, required 1 0 1",
                 q_fs[base], q_last[base+14], q_last[base+15]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream_basic();
    test_throttle();
    test_backpressure();
    test_enable_drop();
    test_gpio_change();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
